datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_sequencer.sv | 98 +++++++++
 tb/tb_datapath_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) that drives register-file
// addresses, ALU op and source select, and counts retired instructions.
module datapath_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic        Flag,
    output logic        Wen,
    output logic [3:0]  WA,
    output logic [3:0]  RAA,
    output logic [3:0]  RAB,
    output logic [2:0]  Op,
    output logic [3:0]  Sel,
    output logic        done,
    output logic        skip,
    output logic        err,
    output logic [15:0] retired_cnt
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t stateQ, stateNext;
    logic   condQ;
    logic   flagQ;
    logic   accept;
    logic   reservedOp;
    logic   writingOp;
    logic   condPass;

    assign accept     = instr_valid && instr_ready;
    assign reservedOp = Op[2] && Op[1];
    assign writingOp  = !reservedOp && (Op != 3'b010);
    assign condPass   = !condQ || flagQ;

    // Fields are captured at the transfer edge so they are already stable in READ
    // and simply hold through IDLE until the next transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= IDLE;
            WA          <= 4'h0;
            RAA         <= 4'h0;
            RAB         <= 4'h0;
            Op          <= 3'b000;
            Sel         <= 4'h0;
            condQ       <= 1'b0;
            flagQ       <= 1'b0;
            retired_cnt <= 16'h0000;
        end else begin
            stateQ <= stateNext;
            if (accept) begin
                Op    <= instr[15:13];
                condQ <= instr[12];
                WA    <= instr[11:8];
                RAA   <= instr[7:4];
                RAB   <= instr[3:0];
                Sel   <= (instr[15:13] == 3'b101) ? {1'b1, instr[2:0]} : 4'h0;
            end
            if (stateQ == READ) begin
                flagQ <= Flag;
            end
            if ((stateQ == WB) && condPass && !reservedOp) begin
                retired_cnt <= retired_cnt + 16'h0001;
            end
        end
    end

    // All handshake and pulse outputs are decoded from the current state, so a
    // reset edge clears them in the very next cycle.
    always_comb begin
        stateNext   = stateQ;
        instr_ready = 1'b0;
        Wen         = 1'b0;
        done        = 1'b0;
        skip        = 1'b0;
        err         = 1'b0;
        case (stateQ)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    stateNext = READ;
                end
            end
            READ: stateNext = EXEC;
            EXEC: stateNext = WB;
            WB: begin
                stateNext = IDLE;
                done      = 1'b1;
                Wen       = writingOp && condPass;
                skip      = !condPass;
                err       = reservedOp;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: the driver queues hand-computed
// expectations, and a monitor checks them whenever done pulses.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        Flag;
    logic        Wen;
    logic [3:0]  WA;
    logic [3:0]  RAA;
    logic [3:0]  RAB;
    logic [2:0]  Op;
    logic [3:0]  Sel;
    logic        done;
    logic        skip;
    logic        err;
    logic [15:0] retired_cnt;

    typedef struct {
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  raa;
        logic [3:0]  rab;
        logic [2:0]  op;
        logic [3:0]  sel;
        logic        skip;
        logic        err;
        logic        retire;
        logic [15:0] retired;
    } exp_t;

    exp_t        expQ[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] expRetired  = 16'h0000;

    datapath_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .Flag        (Flag),
        .Wen         (Wen),
        .WA          (WA),
        .RAA         (RAA),
        .RAB         (RAB),
        .Op          (Op),
        .Sel         (Sel),
        .done        (done),
        .skip        (skip),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Issues one instruction; Flag is wrong everywhere except READ so that any
    // sampling outside READ shows up. With holdValid the next instruction is
    // offered continuously while this one is in flight.
    task automatic applyStimulus(input logic [15:0] ins, input logic flag, input logic holdValid,
                                 input logic [15:0] nextIns, input exp_t e);
        int guard = 0;
        if (e.retire) expRetired = expRetired + 16'h0001;
        e.retired = expRetired;
        expQ.push_back(e);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        Flag        = ~flag;
        while (instr_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_transfer", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = holdValid;
        instr       = holdValid ? nextIns : 16'hFFFF;
        Flag        = flag;
        @(negedge clk);
        checkOutput("ready_read", 32'(instr_ready), 32'd0);
        checkOutput("op_read", 32'(Op), 32'(e.op));
        checkOutput("sel_read", 32'(Sel), 32'(e.sel));
        checkOutput("wa_read", 32'(WA), 32'(e.wa));
        checkOutput("wen_read", 32'(Wen), 32'd0);
        @(posedge clk);
        #1;
        Flag = ~flag;
        @(negedge clk);
        checkOutput("ready_exec", 32'(instr_ready), 32'd0);
        checkOutput("op_exec", 32'(Op), 32'(e.op));
        checkOutput("sel_exec", 32'(Sel), 32'(e.sel));
        checkOutput("wen_exec", 32'(Wen), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_wb", 32'(instr_ready), 32'd0);
        @(posedge clk);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1, required no instruction in flight");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wen_wb", 32'(Wen), 32'(e.wen));
                    checkOutput("wa_wb", 32'(WA), 32'(e.wa));
                    checkOutput("raa_wb", 32'(RAA), 32'(e.raa));
                    checkOutput("rab_wb", 32'(RAB), 32'(e.rab));
                    checkOutput("op_wb", 32'(Op), 32'(e.op));
                    checkOutput("sel_wb", 32'(Sel), 32'(e.sel));
                    checkOutput("skip_wb", 32'(skip), 32'(e.skip));
                    checkOutput("err_wb", 32'(err), 32'(e.err));
                    @(posedge clk);
                    @(negedge clk);
                    checkOutput("retired_cnt", 32'(retired_cnt), 32'(e.retired));
                    checkOutput("ready_after_wb", 32'(instr_ready), 32'd1);
                    checkOutput("wen_after_wb", 32'(Wen), 32'd0);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        Flag        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 32'(instr_ready), 32'd1);
        checkOutput("reset_wen", 32'(Wen), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_skip", 32'(skip), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_wa", 32'(WA), 32'd0);
        checkOutput("reset_raa", 32'(RAA), 32'd0);
        checkOutput("reset_rab", 32'(RAB), 32'd0);
        checkOutput("reset_op", 32'(Op), 32'd0);
        checkOutput("reset_sel", 32'(Sel), 32'd0);
        checkOutput("reset_retired", 32'(retired_cnt), 32'd0);

        //                                              wen   wa    raa   rab   op    sel   skip  err   retire
        applyStimulus(16'h0312, 1'b0, 1'b0, 16'h0, '{1'b1, 4'h3, 4'h1, 4'h2, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0});
        applyStimulus(16'h4045, 1'b0, 1'b0, 16'h0, '{1'b0, 4'h0, 4'h4, 4'h5, 3'd2, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0});
        applyStimulus(16'h9A30, 1'b0, 1'b0, 16'h0, '{1'b0, 4'hA, 4'h3, 4'h0, 3'd4, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0});
        applyStimulus(16'h9A30, 1'b1, 1'b0, 16'h0, '{1'b1, 4'hA, 4'h3, 4'h0, 3'd4, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0});
        applyStimulus(16'hA506, 1'b0, 1'b0, 16'h0, '{1'b1, 4'h5, 4'h0, 4'h6, 3'd5, 4'hE, 1'b0, 1'b0, 1'b1, 16'h0});
        applyStimulus(16'hC000, 1'b0, 1'b1, 16'h0312, '{1'b0, 4'h0, 4'h0, 4'h0, 3'd6, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0});
        applyStimulus(16'h0312, 1'b0, 1'b0, 16'h0, '{1'b1, 4'h3, 4'h1, 4'h2, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0});
        applyStimulus(16'hE0F3, 1'b1, 1'b0, 16'h0, '{1'b0, 4'h0, 4'hF, 4'h3, 3'd7, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0});

        // Reset while the instruction sits in EXEC: it must vanish without a trace.
        @(negedge clk);
        instr       = 16'h0312;
        instr_valid = 1'b1;
        Flag        = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expRetired = 16'h0000;
        @(negedge clk);
        checkOutput("abort_ready", 32'(instr_ready), 32'd1);
        checkOutput("abort_wen", 32'(Wen), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_retired", 32'(retired_cnt), 32'd0);
        checkOutput("abort_op", 32'(Op), 32'd0);

        // Reset coinciding with an offered instruction must not accept it.
        @(negedge clk);
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'hA506;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid_ready", 32'(instr_ready), 32'd1);
        checkOutput("rst_valid_op", 32'(Op), 32'd0);
        checkOutput("rst_valid_sel", 32'(Sel), 32'd0);

        // Preload the counter to its maximum so the next retirement wraps.
        @(negedge clk);
        force dut.retired_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.retired_cnt;
        expRetired = 16'hFFFF;
        applyStimulus(16'h0312, 1'b0, 1'b0, 16'h0, '{1'b1, 4'h3, 4'h1, 4'h2, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0});

        guard = 0;
        while (expQ.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got %0d instructions still pending, required 0", expQ.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
